ysyx_25060170_fetch_unit: RTL and testbench

Parametrised next-generation instruction fetch unit: owns the PC, issues in-order instruction-memory requests with up to `DEPTH` in flight, buffers returned instructions with their PCs, and presents them to the IDU over a valid/ready handshake. Control-flow changes arrive as a single redirect from the EXU; all in-flight and buffered fetches are then squashed, including responses still outstanding in memory. Sits between the instruction-memory port and the IDU.

---
 rtl/ysyx_25060170_fetch_unit.sv | 115 +++++++++++
 tb/tb_ysyx_25060170_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060170_fetch_unit.sv
// Instruction fetch unit. It owns the PC and issues in-order fetches with up to
// DEPTH of them in flight or buffered, then hands instructions to the IDU.
// A redirect squashes all fetches, including responses still pending in memory.
module ysyx_25060170_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_req_valid,
  input  logic            i_req_ready,
  output logic [XLEN-1:0] o_req_addr,
  input  logic            i_rsp_valid,
  input  logic [XLEN-1:0] i_rsp_data,
  input  logic            i_rsp_err,
  output logic            o_inst_valid,
  input  logic            i_inst_ready,
  output logic [XLEN-1:0] o_inst_pc,
  output logic [XLEN-1:0] o_inst,
  output logic            o_inst_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = PW + 1;

  logic [XLEN-1:0] r_pc;
  logic [PW-1:0]   r_alloc;
  logic [PW-1:0]   r_fill;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_drop_cnt;

  logic [XLEN-1:0] r_ent_pc   [DEPTH];
  logic [XLEN-1:0] r_ent_inst [DEPTH];
  logic            r_ent_err  [DEPTH];

  logic [PW-1:0]   w_occ;
  logic [PW-1:0]   w_pend;
  logic [SW-1:0]   w_slots;
  logic            w_issue;
  logic            w_deliver;
  logic            w_drop_en;
  logic            w_fill_en;
  logic [PW-1:0]   w_redirect_drop;
  logic [XLEN-1:0] w_redirect_pc;

  // Occupancy bookkeeping; squashed responses still in memory also hold a slot.
  assign w_occ   = r_alloc - r_head;
  assign w_pend  = r_alloc - r_fill;
  assign w_slots = {1'b0, w_occ} + {1'b0, r_drop_cnt};

  // Request port: held low in reset and during a redirect.
  assign o_req_valid = i_rst && (w_slots < SW'(DEPTH)) && !i_redirect_valid;
  assign o_req_addr  = r_pc;

  // IDU port driven straight from the head entry.
  assign o_inst_valid = (r_fill != r_head) && !i_redirect_valid;
  assign o_inst_pc    = r_ent_pc[r_head[AW-1:0]];
  assign o_inst       = r_ent_inst[r_head[AW-1:0]];
  assign o_inst_err   = r_ent_err[r_head[AW-1:0]];

  assign w_issue   = o_req_valid && i_req_ready;
  assign w_deliver = o_inst_valid && i_inst_ready;
  assign w_drop_en = i_rsp_valid && (r_drop_cnt != '0);
  assign w_fill_en = i_rsp_valid && (r_drop_cnt == '0) && (w_pend != '0);

  // Every outstanding fetch becomes a drop, minus the one answered this cycle.
  assign w_redirect_drop = r_drop_cnt + w_pend - PW'(i_rsp_valid);
  assign w_redirect_pc   = i_redirect_pc & ~XLEN'(3);

  // PC, pointers and drop counter; a redirect overrides every other event.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pc       <= RESET_PC;
      r_alloc    <= '0;
      r_fill     <= '0;
      r_head     <= '0;
      r_drop_cnt <= '0;
    end else if (i_redirect_valid) begin
      r_pc       <= w_redirect_pc;
      r_alloc    <= r_head;
      r_fill     <= r_head;
      r_drop_cnt <= w_redirect_drop;
    end else begin
      if (w_issue) begin
        r_alloc <= r_alloc + PW'(1);
        r_pc    <= r_pc + XLEN'(4);
      end
      if (w_drop_en) begin
        r_drop_cnt <= r_drop_cnt - PW'(1);
      end
      if (w_fill_en) begin
        r_fill <= r_fill + PW'(1);
      end
      if (w_deliver) begin
        r_head <= r_head + PW'(1);
      end
    end
  end

  // Entry payload storage: the PC is written on issue, the instruction on fill.
  always_ff @(posedge i_clk) begin
    if (w_issue) begin
      r_ent_pc[r_alloc[AW-1:0]] <= r_pc;
    end
    if (w_fill_en && !i_redirect_valid) begin
      r_ent_inst[r_fill[AW-1:0]] <= i_rsp_data;
      r_ent_err[r_fill[AW-1:0]]  <= i_rsp_err;
    end
  end

endmodule

// File: tb/tb_ysyx_25060170_fetch_unit.sv
// Directed bench for the fetch unit. The bench acts as an in-order memory with
// programmable latency and logs every request and delivery with its cycle.
module tb_ysyx_25060170_fetch_unit;

  localparam logic [31:0] K = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst;
  logic        inst_err;

  int          passes;
  int          checks;
  int          fails;
  int          cyc;
  int          lat;
  logic [31:0] err_addr;

  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  logic [31:0] rq_addr [$];
  int          rq_cyc  [$];
  logic [31:0] dq_pc   [$];
  logic [31:0] dq_inst [$];
  logic        dq_err  [$];
  int          dq_cyc  [$];

  always #5 clk = ~clk;

  ysyx_25060170_fetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h8000_0000),
    .DEPTH   (4)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_redirect_valid(redirect_valid),
    .i_redirect_pc   (redirect_pc),
    .o_req_valid     (req_valid),
    .i_req_ready     (req_ready),
    .o_req_addr      (req_addr),
    .i_rsp_valid     (rsp_valid),
    .i_rsp_data      (rsp_data),
    .i_rsp_err       (rsp_err),
    .o_inst_valid    (inst_valid),
    .i_inst_ready    (inst_ready),
    .o_inst_pc       (inst_pc),
    .o_inst          (inst),
    .o_inst_err      (inst_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_dq(input string tag, input int idx, input logic [31:0] pc, input logic err);
    chk({tag, "_present"}, 32'(dq_pc.size() > idx), 32'd1);
    if (dq_pc.size() > idx) begin
      chk({tag, "_pc"}, dq_pc[idx], pc);
      chk({tag, "_inst"}, dq_inst[idx], pc ^ K);
      chk({tag, "_err"}, 32'(dq_err[idx]), 32'(err));
    end
  endtask

  // One clock cycle: sample handshakes mid-cycle, then advance the memory model.
  task automatic tick();
    logic        hs_req;
    logic        hs_rsp;
    logic [31:0] a;
    #1;
    hs_req = req_valid & req_ready;
    hs_rsp = rsp_valid;
    a      = req_addr;
    if (inst_valid && inst_ready) begin
      dq_pc.push_back(inst_pc);
      dq_inst.push_back(inst);
      dq_err.push_back(inst_err);
      dq_cyc.push_back(cyc);
    end
    if (hs_req) begin
      rq_addr.push_back(a);
      rq_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      if (hs_rsp && mq_addr.size() > 0) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (hs_req) begin
        mq_addr.push_back(a);
        mq_due.push_back(cyc + lat - 1);
      end
    end
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mq_addr[0] ^ K;
      rsp_err   = (mq_addr[0] == err_addr);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = 32'h0;
      rsp_err   = 1'b0;
    end
  endtask

  task automatic clear_logs();
    mq_addr.delete();
    mq_due.delete();
    rq_addr.delete();
    rq_cyc.delete();
    dq_pc.delete();
    dq_inst.delete();
    dq_err.delete();
    dq_cyc.delete();
    rsp_valid = 1'b0;
    rsp_data  = 32'h0;
    rsp_err   = 1'b0;
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    clear_logs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    passes = 0; checks = 0; fails = 0; cyc = 0; lat = 1;
    err_addr = 32'h1;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    req_ready = 1'b1; inst_ready = 1'b1;
    rsp_valid = 1'b0; rsp_data = 32'h0; rsp_err = 1'b0;

    // Reset state.
    #2;
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);

    // Streaming with 1-cycle memory.
    lat = 1;
    do_reset();
    #1;
    chk("t1_first_valid", 32'(req_valid), 32'd1);
    chk("t1_first_addr", req_addr, 32'h8000_0000);
    for (int i = 0; i < 10; i++) tick();
    chk("t1_nreq", 32'(rq_addr.size()), 32'd10);
    for (int k = 0; k < 6 && k < rq_addr.size(); k++) begin
      chk("t1_req_addr", rq_addr[k], 32'h8000_0000 + 32'(4 * k));
      chk("t1_req_cyc", 32'(rq_cyc[k]), 32'(rq_cyc[0] + k));
    end
    for (int k = 0; k < 6; k++) begin
      chk_dq("t1_dq", k, 32'h8000_0000 + 32'(4 * k), 1'b0);
      if (dq_cyc.size() > k) chk("t1_dq_cyc", 32'(dq_cyc[k]), 32'(rq_cyc[0] + 2 + k));
    end

    // Back-pressure: buffer fills with exactly DEPTH fetches.
    inst_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    chk("t2_nreq", 32'(rq_addr.size()), 32'd4);
    chk("t2_full_req_valid", 32'(req_valid), 32'd0);
    chk("t2_head_valid", 32'(inst_valid), 32'd1);
    chk("t2_head_pc", inst_pc, 32'h8000_0000);
    inst_ready = 1'b1;
    tick();
    chk("t2_ndeliv", 32'(dq_pc.size()), 32'd1);
    chk("t2_freed_req_valid", 32'(req_valid), 32'd1);
    chk("t2_freed_req_addr", req_addr, 32'h8000_0010);
    for (int i = 0; i < 6; i++) tick();
    for (int k = 0; k < 4; k++) chk_dq("t2_dq", k, 32'h8000_0000 + 32'(4 * k), 1'b0);
    chk("t2_nreq_after", 32'(rq_addr.size() >= 5), 32'd1);
    if (rq_addr.size() >= 5 && dq_cyc.size() >= 1) begin
      chk("t2_req5_addr", rq_addr[4], 32'h8000_0010);
      chk("t2_req5_cyc", 32'(rq_cyc[4]), 32'(dq_cyc[0] + 1));
    end

    // Redirect with three fetches outstanding in a 3-cycle memory.
    lat = 3;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    chk("t3_nreq", 32'(rq_addr.size()), 32'd3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    #1;
    chk("t3_redir_req_valid", 32'(req_valid), 32'd0);
    chk("t3_redir_inst_valid", 32'(inst_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t3_new_req_valid", 32'(req_valid), 32'd1);
    chk("t3_new_req_addr", req_addr, 32'h8000_0100);
    for (int i = 0; i < 10; i++) tick();
    chk_dq("t3_dq0", 0, 32'h8000_0100, 1'b0);
    chk_dq("t3_dq1", 1, 32'h8000_0104, 1'b0);

    // Redirect coinciding with a response and a ready IDU with a valid head.
    lat = 2;
    inst_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    chk("t4_head_valid", 32'(inst_valid), 32'd1);
    chk("t4_head_pc", inst_pc, 32'h8000_0000);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0040;
    inst_ready     = 1'b1;
    #1;
    chk("t4_redir_inst_valid", 32'(inst_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t4_no_delivery", 32'(dq_pc.size()), 32'd0);
    chk("t4_empty", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    chk_dq("t4_dq0", 0, 32'h8000_0040, 1'b0);
    chk_dq("t4_dq1", 1, 32'h8000_0044, 1'b0);

    // Access fault carried on one entry only.
    lat = 1;
    err_addr = 32'h8000_0008;
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    chk_dq("t5_dq1", 1, 32'h8000_0004, 1'b0);
    chk_dq("t5_dq2", 2, 32'h8000_0008, 1'b1);
    chk_dq("t5_dq3", 3, 32'h8000_000C, 1'b0);
    err_addr = 32'h1;

    // PC wrap at the top of the address space.
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    #1;
    chk("t6_redir_req_valid", 32'(req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t6_top_req_valid", 32'(req_valid), 32'd1);
    chk("t6_top_req_addr", req_addr, 32'hFFFF_FFFC);
    tick();
    chk("t6_wrap_req_addr", req_addr, 32'h0000_0000);
    for (int i = 0; i < 4; i++) tick();
    chk_dq("t6_dq0", 0, 32'hFFFF_FFFC, 1'b0);
    chk_dq("t6_dq1", 1, 32'h0000_0000, 1'b0);

    // Reset asserted mid-stream.
    chk("t7_pre_inst_valid", 32'(inst_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("t7_rst_req_valid", 32'(req_valid), 32'd0);
    chk("t7_rst_inst_valid", 32'(inst_valid), 32'd0);
    clear_logs();
    tick();
    rst = 1'b1;
    #1;
    chk("t7_restart_valid", 32'(req_valid), 32'd1);
    chk("t7_restart_addr", req_addr, 32'h8000_0000);
    for (int i = 0; i < 4; i++) tick();
    chk_dq("t7_dq0", 0, 32'h8000_0000, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
